// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: decides per-cycle register enables,
// NOP insertion and memory-timeout handling for a 5-stage in-order core.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load_use_stall      ID hazard request
//   branch_taken_EX     redirect resolved in EX
//   dmem_req, dmem_ack  data-memory handshake from MEM
//   pc_we, ifid_we, exmem_we        register write enables
//   ifid_flush, idex_flush, memwb_bubble  NOP insertion
//   mem_err             sticky timeout flag
//   state               RUN=0, MEM_WAIT=1, ERR=2
//   stall_cnt, flush_cnt  saturating performance counters
module pipe_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_stall,
   input  logic             branch_taken_EX,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             exmem_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int HW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_pend;
   logic [HW-1:0]    r_hold;
   logic [CNT_W-1:0] r_stall;
   logic [CNT_W-1:0] r_flush;

   logic w_err;
   logic w_mem_hold;
   logic w_br;
   logic w_timeout;
   logic w_hold_path;
   logic w_br_path;
   logic w_lu_path;
   logic w_stall_inc;

   assign w_err      = (r_state == S_ERR);
   assign w_mem_hold = ((r_state == S_RUN) && dmem_req && !dmem_ack) ||
                       ((r_state == S_WAIT) && !dmem_ack);
   assign w_br       = branch_taken_EX || r_pend;
   // This hold cycle is the last one allowed before the timeout fires
   assign w_timeout  = w_mem_hold && (r_hold == HOLD_LAST);

   // Mutually exclusive decode of the priority chain
   assign w_hold_path = w_mem_hold;
   assign w_br_path   = !w_err && !w_mem_hold && w_br;
   assign w_lu_path   = !w_err && !w_mem_hold && !w_br &&
                        load_use_stall;

   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      exmem_we     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      unique case (1'b1)
         w_err: begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
         end
         w_hold_path: begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
         end
         w_br_path: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         w_lu_path: begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN: begin
            if (w_mem_hold)
               w_next = w_timeout ? S_ERR : S_WAIT;
         end
         S_WAIT: begin
            if (dmem_ack)
               w_next = S_RUN;
            else if (w_timeout)
               w_next = S_ERR;
         end
         S_ERR:   w_next = S_ERR;
         default: w_next = S_RUN;
      endcase
   end

   assign w_stall_inc = !pc_we && !w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_pend  <= 1'b0;
         r_hold  <= '0;
         r_stall <= '0;
         r_flush <= '0;
      end else begin
         r_state <= w_next;
         if (w_mem_hold) begin
            r_hold <= r_hold + 1'b1;
            // A redirect seen while held is replayed on release
            r_pend <= r_pend | branch_taken_EX;
         end else begin
            r_hold <= '0;
            r_pend <= 1'b0;
         end
         if (w_stall_inc && (r_stall != '1))
            r_stall <= r_stall + 1'b1;
         if (w_br_path && (r_flush != '1))
            r_flush <= r_flush + 1'b1;
      end
   end

   assign mem_err   = w_err;
   assign state     = r_state;
   assign stall_cnt = r_stall;
   assign flush_cnt = r_flush;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lu, bt, req, ack;
   logic       pc_we, ifid_we, exmem_we;
   logic       ifid_flush, idex_flush, memwb_bubble, mem_err;
   logic [1:0] state;
   logic [3:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;
   bit run_cmp = 1'b0;

   // Behavioural model: mode 0 run, 1 waiting on memory, 2 error
   int m_state, m_hold, m_stall, m_flush;
   bit m_pend;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_stall(lu), .branch_taken_EX(bt),
      .dmem_req(req), .dmem_ack(ack),
      .pc_we(pc_we), .ifid_we(ifid_we), .exmem_we(exmem_we),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .memwb_bubble(memwb_bubble), .mem_err(mem_err),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit f_hold();
      return (m_state == 0 && req && !ack) || (m_state == 1 && !ack);
   endfunction

   function automatic bit f_br();
      return bt || m_pend;
   endfunction

   function automatic bit f_stall();
      return m_state != 2 && (f_hold() || (!f_br() && lu));
   endfunction

   function automatic bit f_flush();
      return m_state != 2 && !f_hold() && f_br();
   endfunction

   // {pc_we, ifid_we, exmem_we, ifid_flush, idex_flush, bubble, err}
   function automatic logic [6:0] f_out();
      if (m_state == 2) return 7'b0000001;
      if (f_hold())     return 7'b0000010;
      if (f_br())       return 7'b1111100;
      if (lu)           return 7'b0010100;
      return 7'b1110000;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_hold  <= 0;
         m_pend  <= 1'b0;
         m_stall <= 0;
         m_flush <= 0;
      end else if (m_state != 2) begin
         if (f_hold()) begin
            m_hold  <= m_hold + 1;
            m_pend  <= m_pend | bt;
            m_state <= (m_hold + 1 >= 16) ? 2 : 1;
         end else begin
            m_hold  <= 0;
            m_pend  <= 1'b0;
            m_state <= 0;
         end
         if (f_stall() && m_stall < 15) m_stall <= m_stall + 1;
         if (f_flush() && m_flush < 15) m_flush <= m_flush + 1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("model_outs", {pc_we, ifid_we, exmem_we, ifid_flush,
                            idex_flush, memwb_bubble, mem_err}, f_out());
         chk("model_state", state, m_state);
         chk("model_stall", stall_cnt, m_stall);
         chk("model_flush", flush_cnt, m_flush);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      lu = 0; bt = 0; req = 0; ack = 0;
      rst_n = 1'b0;
      @(negedge clk);
      cyc();
      rst_n = 1'b1;
   endtask

   logic [3:0] vec [0:11];

   initial begin
      rst_n = 1'b0;
      lu = 0; bt = 0; req = 0; ack = 0;
      run_cmp = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_pc_we", pc_we, 1);
      chk("rst_ifid_we", ifid_we, 1);
      chk("rst_exmem_we", exmem_we, 1);
      chk("rst_flushes", {ifid_flush, idex_flush, memwb_bubble}, 0);
      chk("rst_state", state, 0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
      cyc();
      rst_n = 1'b1;

      // Single load-use stall
      do_reset();
      lu = 1;
      @(negedge clk);
      chk("lu_pc_we", pc_we, 0);
      chk("lu_ifid_we", ifid_we, 0);
      chk("lu_idex_flush", idex_flush, 1);
      chk("lu_ifid_flush", ifid_flush, 0);
      chk("lu_exmem_we", exmem_we, 1);
      cyc();
      lu = 0;
      @(negedge clk);
      chk("lu_stall_cnt", stall_cnt, 1);

      // Branch beats load-use
      do_reset();
      bt = 1; lu = 1;
      @(negedge clk);
      chk("br_lu_flushes", {ifid_flush, idex_flush}, 2'b11);
      chk("br_lu_pc_we", pc_we, 1);
      cyc();
      bt = 0; lu = 0;
      @(negedge clk);
      chk("br_lu_flush_cnt", flush_cnt, 1);
      chk("br_lu_stall_cnt", stall_cnt, 0);

      // Memory wait, ack on the fourth cycle
      do_reset();
      req = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mw_bubble", memwb_bubble, 1);
         chk("mw_state", state, (i == 0) ? 0 : 1);
         cyc();
      end
      ack = 1;
      @(negedge clk);
      chk("mw_ack_state", state, 1);
      chk("mw_ack_bubble", memwb_bubble, 0);
      chk("mw_ack_pc_we", pc_we, 1);
      cyc();
      req = 0; ack = 0;
      @(negedge clk);
      chk("mw_done_state", state, 0);
      chk("mw_stall_cnt", stall_cnt, 3);

      // Branch arriving while held is deferred to release
      do_reset();
      req = 1; bt = 1;
      @(negedge clk);
      chk("mwb_hold_flush", {ifid_flush, idex_flush}, 0);
      cyc();
      bt = 0;
      @(negedge clk);
      chk("mwb_hold2_flush", {ifid_flush, idex_flush}, 0);
      cyc();
      ack = 1;
      @(negedge clk);
      chk("mwb_rel_flush", {ifid_flush, idex_flush}, 2'b11);
      chk("mwb_rel_pc_we", pc_we, 1);
      cyc();
      req = 0; ack = 0;
      @(negedge clk);
      chk("mwb_after_flush", ifid_flush, 0);
      chk("mwb_flush_cnt", flush_cnt, 1);
      chk("mwb_stall_cnt", stall_cnt, 2);

      // Timeout into error, then reset recovery
      do_reset();
      req = 1;
      repeat (15) cyc();
      @(negedge clk);
      chk("to_15_state", state, 1);
      cyc();
      @(negedge clk);
      chk("to_state", state, 2);
      chk("to_mem_err", mem_err, 1);
      chk("to_enables", {pc_we, ifid_we, exmem_we}, 0);
      chk("to_bubble", memwb_bubble, 0);
      chk("to_stall_sat", stall_cnt, 15);
      cyc();
      req = 0; ack = 1; bt = 1; lu = 1;
      @(negedge clk);
      chk("err_sticky", {state, mem_err}, 3'b101);
      cyc();
      rst_n = 1'b0;
      @(negedge clk);
      chk("err_rst_state", state, 0);
      chk("err_rst_cnts", {stall_cnt, flush_cnt}, 0);
      chk("err_rst_mem_err", mem_err, 0);
      cyc();
      rst_n = 1'b1;
      lu = 0; bt = 0; ack = 0;

      // Counter saturation
      do_reset();
      lu = 1;
      repeat (20) cyc();
      lu = 0;
      @(negedge clk);
      chk("sat_stall_cnt", stall_cnt, 15);

      // Reset mid-wait discards the pending redirect
      do_reset();
      req = 1; bt = 1;
      cyc();
      req = 0; bt = 0;
      do_reset();
      @(negedge clk);
      chk("rst_mid_flush", {ifid_flush, idex_flush}, 0);
      chk("rst_mid_pc_we", pc_we, 1);
      chk("rst_mid_state", state, 0);

      // Mixed sequence, checked by the model each cycle: {lu,bt,req,ack}
      vec[0] = 4'b1000; vec[1] = 4'b0100; vec[2] = 4'b1110;
      vec[3] = 4'b1010; vec[4] = 4'b1001; vec[5] = 4'b0000;
      vec[6] = 4'b0011; vec[7] = 4'b1100; vec[8] = 4'b0110;
      vec[9] = 4'b0001; vec[10] = 4'b1000; vec[11] = 4'b0000;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         {lu, bt, req, ack} = vec[i];
         cyc();
      end
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: consecutive memory-hold cycles before the error state is entered.
REQ-003 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-004 clk  in  1  pipeline clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 load_use_stall  in  1  load-use hazard request from the ID-stage hazard detector.
REQ-007 branch_taken_EX  in  1  branch/jump redirect resolved in EX.
REQ-008 dmem_req  in  1  MEM stage is issuing a data-memory access this cycle.
REQ-009 dmem_ack  in  1  data memory completes the access this cycle.
REQ-010 pc_we / ifid_we / exmem_we  out  1 each  register write enables.
REQ-011 ifid_flush / idex_flush  out  1 each  insert a NOP into IF/ID or ID/EX.
REQ-012 memwb_bubble  out  1  insert a NOP into MEM/WB.
REQ-013 mem_err  out  1  sticky memory-timeout error flag.
REQ-014 state  out  2  current state: RUN=0, MEM_WAIT=1, ERR=2.
REQ-015 stall_cnt / flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-016 Outputs SHALL be combinational from the registered state, the pend_flush and hold_cnt registers, and the inputs; state, counters, pend_flush and hold_cnt SHALL update on the rising edge of clk.
REQ-017 The hold condition mem_hold SHALL be: (RUN and dmem_req and !dmem_ack) or (MEM_WAIT and !dmem_ack).
REQ-018 Input priority SHALL be: ERR, then mem_hold, then the effective branch, then load_use_stall.
REQ-019 The effective branch br SHALL be branch_taken_EX OR pend_flush.
REQ-020 In ERR, all enables, all flushes and memwb_bubble SHALL be 0; mem_err=1 until reset.
REQ-021 When mem_hold is true: pc_we=ifid_we=exmem_we=0; ifid_flush=idex_flush=0; memwb_bubble=1.
REQ-022 When mem_hold is true and branch_taken_EX=1, pend_flush SHALL be set at the clock edge.
REQ-023 When mem_hold is false and br=1: pc_we=ifid_we=exmem_we=1; ifid_flush=idex_flush=1; load_use_stall is ignored.
REQ-024 When mem_hold is false, br=0 and load_use_stall=1: pc_we=ifid_we=0; exmem_we=1; idex_flush=1; ifid_flush=0.
REQ-025 Otherwise, all write enables SHALL be 1 and all flushes and memwb_bubble SHALL be 0.
REQ-026 pend_flush SHALL clear at the edge of any non-hold cycle outside ERR.
REQ-027 Transitions: RUN->MEM_WAIT on mem_hold; MEM_WAIT->RUN on dmem_ack; RUN/MEM_WAIT->ERR on the edge ending the MEM_TIMEOUT-th consecutive mem_hold cycle; ERR exits only by reset.
REQ-028 hold_cnt SHALL increment on each mem_hold cycle and clear on any non-hold cycle.
REQ-029 In MEM_WAIT, dmem_ack=1 SHALL release in that same cycle, with outputs per REQ-023..025.
REQ-030 stall_cnt SHALL increment in every cycle where pc_we=0 and the state is not ERR, and saturate at all-ones.
REQ-031 flush_cnt SHALL increment in every cycle where REQ-023 applies, and saturate at all-ones.

Reset
REQ-032 While rst_n=0: state=RUN; pend_flush=0; hold_cnt=0; stall_cnt=flush_cnt=0; mem_err=0.
REQ-033 With rst_n=0 and all inputs 0, the combinational outputs SHALL read pc_we=ifid_we=exmem_we=1 and all flushes 0.
REQ-034 Asserting reset mid-MEM_WAIT or in ERR SHALL abandon any pending flush and hold without residue.
REQ-035 The first cycle after deassertion SHALL behave as RUN.

Verification
REQ-036 Load-use: load_use_stall=1 for one cycle -> pc_we=ifid_we=0, idex_flush=1, exmem_we=1; stall_cnt=1 after the edge.
REQ-037 Branch plus load-use in the same cycle -> ifid_flush=idex_flush=1, pc_we=1; flush_cnt=1, stall_cnt=0.
REQ-038 Memory wait: dmem_req=1, ack after 3 cycles -> state=1 for 3 cycles, memwb_bubble=1 for 3 cycles, release on the ack cycle; stall_cnt=3.
REQ-039 Branch during the memory wait -> no flush while held; on the ack cycle ifid_flush=idex_flush=1; flush_cnt=1.
REQ-040 Timeout: dmem_req=1 with dmem_ack=0 for 16 cycles -> state=2, mem_err=1, all enables 0; rst_n pulse -> state=0, counters 0.
REQ-041 Saturation with CNT_W=4: 20 load-use cycles -> stall_cnt=15.
